// File: rtl/pspin_hostmem_ar_splitter.sv
// Splits upstream AXI INCR read bursts so no downstream burst crosses BOUNDARY; R is stitched back.
// Optional split statistics counter: define PSPIN_HOSTMEM_AR_SPLIT_STATS_EN.
module pspin_hostmem_ar_splitter #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned BOUNDARY   = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   // upstream AR
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   // upstream R
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   // downstream AR
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   // downstream R
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [31:0]           split_count
);

   localparam int unsigned NB     = DATA_WIDTH / 8;
   localparam int unsigned NB_LOG = $clog2(NB);
   localparam logic [ADDR_WIDTH-1:0] BOUND_A = ADDR_WIDTH'(BOUNDARY);
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {StIdle, StIssueAr, StWaitR, StLocalErr} state_e;

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic [8:0]            rem_q, rem_d;
   logic                  last_sub_q, last_sub_d;

   logic [ADDR_WIDTH-1:0] size_mask, addr_aligned, btb;
   logic [8:0]            n_beats, n_beats_m1;

   // Downstream R id is replaced by the latched upstream id.
   logic unused_rid;
   assign unused_rid = ^m_axi_rid;

   // Sub-burst sizing: beats left before the next BOUNDARY crossing.
   always_comb begin
      size_mask    = (ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1);
      addr_aligned = addr_q & ~size_mask;
      btb          = (BOUND_A - (addr_aligned & (BOUND_A - ADDR_WIDTH'(1)))) >> size_q;
      if (burst_q == BURST_INCR && btb < ADDR_WIDTH'(rem_q)) begin
         n_beats = btb[8:0];
      end else begin
         n_beats = rem_q;
      end
      n_beats_m1 = n_beats - 9'd1;
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      size_d     = size_q;
      burst_d    = burst_q;
      rem_d      = rem_q;
      last_sub_d = last_sub_q;
      case (state_q)
         StIdle: begin
            if (s_axi_arvalid) begin
               id_d    = s_axi_arid;
               addr_d  = s_axi_araddr;
               size_d  = s_axi_arsize;
               burst_d = s_axi_arburst;
               rem_d   = 9'(s_axi_arlen) + 9'd1;
               state_d = (32'(s_axi_arsize) > NB_LOG) ? StLocalErr : StIssueAr;
            end
         end
         StIssueAr: begin
            if (m_axi_arready) begin
               addr_d     = addr_aligned + (ADDR_WIDTH'(n_beats) << size_q);
               rem_d      = rem_q - n_beats;
               last_sub_d = (rem_q == n_beats);
               state_d    = StWaitR;
            end
         end
         StWaitR: begin
            if (m_axi_rvalid && s_axi_rready && m_axi_rlast) begin
               state_d = last_sub_q ? StIdle : StIssueAr;
            end
         end
         StLocalErr: begin
            if (s_axi_rready) begin
               rem_d = rem_q - 9'd1;
               if (rem_q == 9'd1) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      s_axi_arready = (state_q == StIdle);
      m_axi_arvalid = (state_q == StIssueAr);
      m_axi_arid    = id_q;
      m_axi_araddr  = addr_q;
      m_axi_arlen   = n_beats_m1[7:0];
      m_axi_arsize  = size_q;
      m_axi_arburst = burst_q;
      s_axi_rid     = id_q;
      s_axi_rdata   = m_axi_rdata;
      s_axi_rresp   = m_axi_rresp;
      s_axi_rlast   = 1'b0;
      s_axi_rvalid  = 1'b0;
      m_axi_rready  = 1'b0;
      if (state_q == StWaitR) begin
         s_axi_rvalid = m_axi_rvalid;
         s_axi_rlast  = m_axi_rlast && last_sub_q;
         m_axi_rready = s_axi_rready;
      end else if (state_q == StLocalErr) begin
         s_axi_rvalid = 1'b1;
         s_axi_rdata  = '0;
         s_axi_rresp  = RESP_SLVERR;
         s_axi_rlast  = (rem_q == 9'd1);
      end
      // Nothing handshakes while reset is asserted.
      if (rst) begin
         s_axi_arready = 1'b0;
         m_axi_arvalid = 1'b0;
         s_axi_rvalid  = 1'b0;
         s_axi_rlast   = 1'b0;
         m_axi_rready  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         id_q       <= '0;
         addr_q     <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         rem_q      <= '0;
         last_sub_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         rem_q      <= rem_d;
         last_sub_q <= last_sub_d;
      end
   end

`ifdef PSPIN_HOSTMEM_AR_SPLIT_STATS_EN
   logic        first_q;
   logic [31:0] split_cnt_q;

   // first_q marks the first sub-burst of the current upstream burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         first_q     <= 1'b0;
         split_cnt_q <= '0;
      end else begin
         if (state_q == StIdle && s_axi_arvalid) begin
            first_q <= 1'b1;
         end else if (state_q == StIssueAr && m_axi_arready) begin
            first_q <= 1'b0;
            if (first_q && n_beats != rem_q) begin
               split_cnt_q <= split_cnt_q + 32'd1;
            end
         end
      end
   end

   assign split_count = split_cnt_q;
`else
   assign split_count = 32'h0;
`endif

endmodule

// File: tb/tb_pspin_hostmem_ar_splitter.sv
// Randomised bench for pspin_hostmem_ar_splitter against a burst-level splitting model.
module tb_pspin_hostmem_ar_splitter;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 512;
   localparam int unsigned IW = 8;
   localparam longint unsigned BOUND = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] s_axi_arid;
   logic [AW-1:0] s_axi_araddr;
   logic [7:0]    s_axi_arlen;
   logic [2:0]    s_axi_arsize;
   logic [1:0]    s_axi_arburst;
   logic          s_axi_arvalid;
   logic          s_axi_arready;
   logic [IW-1:0] s_axi_rid;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rlast;
   logic          s_axi_rvalid;
   logic          s_axi_rready;
   logic [IW-1:0] m_axi_arid;
   logic [AW-1:0] m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arvalid;
   logic          m_axi_arready;
   logic [IW-1:0] m_axi_rid;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0]    m_axi_rresp;
   logic          m_axi_rlast;
   logic          m_axi_rvalid;
   logic          m_axi_rready;
   logic [31:0]   split_count;

   pspin_hostmem_ar_splitter dut (
      .clk(clk), .rst(rst),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .split_count(split_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [IW-1:0] id;
      logic [2:0]    size;
      logic [1:0]    burst;
   } ar_t;

   ar_t           dn_ar_q[$];
   int            slave_len_q[$];
   logic [DW-1:0] sent_data_q[$];
   logic [DW-1:0] up_data_q[$];
   logic [1:0]    up_resp_q[$];
   logic          up_last_q[$];
   logic [IW-1:0] up_id_q[$];

   int          errors = 0;
   int          checks = 0;
   bit          stall_en = 1'b0;
   logic [31:0] exp_split = 32'h0;

   // Downstream slave, upstream R sink and monitors. Sample at negedge, drive after posedge.
   initial begin : slave_proc
      int  slave_beat;
      bit  dn_hs;
      slave_beat    = 0;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rid     = '0;
      s_axi_rready  = 1'b0;
      forever begin
         @(negedge clk);
         dn_hs = 1'b0;
         if (rst) begin
            slave_len_q.delete();
            slave_beat = 0;
         end else begin
            if (m_axi_arvalid && m_axi_arready) begin
               dn_ar_q.push_back('{m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize,
                                   m_axi_arburst});
               slave_len_q.push_back(int'(m_axi_arlen) + 1);
            end
            if (m_axi_rvalid && m_axi_rready) begin
               dn_hs = 1'b1;
               sent_data_q.push_back(m_axi_rdata);
               slave_beat++;
               if (slave_len_q.size() > 0 && slave_beat == slave_len_q[0]) begin
                  void'(slave_len_q.pop_front());
                  slave_beat = 0;
               end
            end
            if (s_axi_rvalid && s_axi_rready) begin
               up_data_q.push_back(s_axi_rdata);
               up_resp_q.push_back(s_axi_rresp);
               up_last_q.push_back(s_axi_rlast);
               up_id_q.push_back(s_axi_rid);
            end
         end
         @(posedge clk);
         #1;
         m_axi_arready = ($urandom_range(0, 3) != 0);
         if (rst || dn_hs || !m_axi_rvalid) begin
            if (!rst && slave_len_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               m_axi_rvalid = 1'b1;
               for (int k = 0; k < DW / 32; k++) m_axi_rdata[k*32 +: 32] = $urandom;
               m_axi_rlast = (slave_beat == slave_len_q[0] - 1);
               m_axi_rid   = IW'($urandom);
               m_axi_rresp = 2'b00;
            end else begin
               m_axi_rvalid = 1'b0;
               m_axi_rlast  = 1'b0;
            end
         end
         s_axi_rready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_logs();
      dn_ar_q.delete();
      sent_data_q.delete();
      up_data_q.delete();
      up_resp_q.delete();
      up_last_q.delete();
      up_id_q.delete();
   endtask

   // Reference: walk the burst, cutting it wherever it would cross a BOUNDARY.
   task automatic model_split(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, output ar_t exp_q[$]);
      longint unsigned a, al, btb, n, rem;
      bit first;
      exp_q.delete();
      if (size > 3'd6) return;
      if (burst != 2'b01) begin
         exp_q.push_back('{addr, len, id, size, burst});
         return;
      end
      a = addr;
      rem = longint'(len) + 1;
      first = 1'b1;
      while (rem > 0) begin
         al  = a - (a % (64'd1 << size));
         btb = (BOUND - (al % BOUND)) / (64'd1 << size);
         n   = (rem < btb) ? rem : btb;
         exp_q.push_back('{first ? a : al, 8'(n - 1), id, size, burst});
         a = al + n * (64'd1 << size);
         rem -= n;
         first = 1'b0;
      end
   endtask

   task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input string name);
      bit done = 1'b0;
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b1;
      s_axi_arid    = id;
      s_axi_araddr  = addr;
      s_axi_arlen   = len;
      s_axi_arsize  = size;
      s_axi_arburst = burst;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (s_axi_arready) done = 1'b1;
      end
      @(posedge clk);
      #1;
      s_axi_arvalid = 1'b0;
      if (!done) begin
         errors++;
         $display("FAIL %s ar_accept: got arready=0 for 100 cycles, required 1", name);
      end
   endtask

   task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input string name);
      ar_t exp_q[$];
      int  nbeats = int'(len) + 1;
      bit  is_err = (size > 3'd6);
      bit  done = 1'b0;
      model_split(id, addr, len, size, burst, exp_q);
`ifdef PSPIN_HOSTMEM_AR_SPLIT_STATS_EN
      if (exp_q.size() > 1) exp_split++;
`endif
      clear_logs();
      send_ar(id, addr, len, size, burst, name);
      for (int c = 0; c < 6000 && !done; c++) begin
         @(posedge clk);
         #2;
         if (up_last_q.size() >= nbeats) done = 1'b1;
      end
      repeat (6) @(posedge clk);
      #2;
      checks++;
      if (dn_ar_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s ar_count: got %0d downstream ARs, required %0d", name,
                  dn_ar_q.size(), exp_q.size());
      end
      for (int i = 0; i < dn_ar_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (dn_ar_q[i].addr !== exp_q[i].addr || dn_ar_q[i].len !== exp_q[i].len ||
             dn_ar_q[i].id !== exp_q[i].id || dn_ar_q[i].size !== exp_q[i].size ||
             dn_ar_q[i].burst !== exp_q[i].burst) begin
            errors++;
            $display("FAIL %s ar[%0d]: got addr=%h len=%0d id=%h size=%0d burst=%0d, required addr=%h len=%0d id=%h size=%0d burst=%0d",
                     name, i, dn_ar_q[i].addr, dn_ar_q[i].len, dn_ar_q[i].id, dn_ar_q[i].size,
                     dn_ar_q[i].burst, exp_q[i].addr, exp_q[i].len, exp_q[i].id,
                     exp_q[i].size, exp_q[i].burst);
         end
      end
      checks++;
      if (up_last_q.size() != nbeats) begin
         errors++;
         $display("FAIL %s beat_count: got %0d upstream beats, required %0d", name,
                  up_last_q.size(), nbeats);
      end
      for (int i = 0; i < up_last_q.size() && i < nbeats; i++) begin
         logic [DW-1:0] ed;
         logic [1:0]    er;
         ed = is_err ? '0 : ((i < sent_data_q.size()) ? sent_data_q[i] : 'x);
         er = is_err ? 2'b10 : 2'b00;
         checks++;
         if (up_data_q[i] !== ed || up_resp_q[i] !== er || up_id_q[i] !== id ||
             up_last_q[i] !== (i == nbeats - 1)) begin
            errors++;
            $display("FAIL %s beat[%0d]: got resp=%0d last=%0d id=%h data[63:0]=%h, required resp=%0d last=%0d id=%h data[63:0]=%h",
                     name, i, up_resp_q[i], up_last_q[i], up_id_q[i], up_data_q[i][63:0],
                     er, (i == nbeats - 1), id, ed[63:0]);
         end
      end
      checks++;
      if (split_count !== exp_split) begin
         errors++;
         $display("FAIL %s split_count: got %0d, required %0d", name, split_count, exp_split);
      end
   endtask

   task automatic check_reset_outputs(input string name, input bit in_reset);
      @(negedge clk);
      checks++;
      if (s_axi_arready !== !in_reset || m_axi_arvalid !== 1'b0 || s_axi_rvalid !== 1'b0 ||
          s_axi_rlast !== 1'b0 || m_axi_rready !== 1'b0 || split_count !== 32'h0) begin
         errors++;
         $display("FAIL %s: got arready=%b arvalid=%b rvalid=%b rlast=%b m_rready=%b split=%0d, required arready=%b others 0",
                  name, s_axi_arready, m_axi_arvalid, s_axi_rvalid, s_axi_rlast, m_axi_rready,
                  split_count, !in_reset);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      check_reset_outputs("reset_during", 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("reset_after", 1'b0);
   endtask

   task automatic test_split_boundary();
      run_burst(8'h11, 64'h0FC0, 8'd3, 3'd6, 2'b01, "incr_cross_4k");
   endtask

   task automatic test_aligned_single();
      run_burst(8'h22, 64'h2000, 8'd63, 3'd6, 2'b01, "incr_one_page");
   endtask

   task automatic test_long_split_stall();
      stall_en = 1'b1;
      run_burst(8'h33, 64'h0, 8'd255, 3'd6, 2'b01, "incr_256_stall");
      stall_en = 1'b0;
   endtask

   task automatic test_fixed();
      run_burst(8'hC7, 64'h0FF0, 8'd3, 3'd4, 2'b00, "fixed_unsplit");
   endtask

   task automatic test_local_err();
      stall_en = 1'b1;
      run_burst(8'h5A, 64'h1234, 8'd1, 3'd7, 2'b01, "local_slverr");
      stall_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      clear_logs();
      send_ar(8'h44, 64'h0FC0, 8'd3, 3'd6, 2'b01, "reset_mid_ar");
      for (int c = 0; c < 400 && !seen; c++) begin
         @(posedge clk);
         #2;
         if (dn_ar_q.size() >= 2) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_mid second_ar: got %0d downstream ARs, required 2", dn_ar_q.size());
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_split = 32'h0;
      clear_logs();
      check_reset_outputs("reset_mid_after", 1'b0);
      repeat (20) @(posedge clk);
      #2;
      checks++;
      if (up_last_q.size() != 0 || dn_ar_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid abandoned: got %0d beats %0d ARs after reset, required 0 and 0",
                  up_last_q.size(), dn_ar_q.size());
      end
      run_burst(8'h45, 64'h0FC0, 8'd3, 3'd6, 2'b01, "reset_mid_next");
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         logic [AW-1:0] a;
         logic [2:0]    sz;
         logic [1:0]    bt;
         a  = {44'h0, 20'($urandom)};
         sz = 3'($urandom_range(0, 6));
         if ($urandom_range(0, 9) == 0) sz = 3'd7;
         bt = 2'($urandom_range(0, 2));
         stall_en = $urandom_range(0, 1) != 0;
         run_burst(8'($urandom), a, 8'($urandom_range(0, 255)), sz, bt, "random");
      end
      stall_en = 1'b0;
   endtask

   initial begin
      s_axi_arvalid = 1'b0;
      s_axi_arid    = '0;
      s_axi_araddr  = '0;
      s_axi_arlen   = '0;
      s_axi_arsize  = '0;
      s_axi_arburst = '0;
      test_reset();
      test_split_boundary();
      test_aligned_single();
      test_long_split_stall();
      test_fixed();
      test_local_err();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
